// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Divides the system clock down to a pixel enable (p_tick), runs the
// horizontal/vertical counters, and produces registered hsync/vsync/video_on
// that always line up with the x/y coordinates handed to the renderers.
// Optional feature: define VGA_FRAME_COUNT_EN to build the 8-bit frame
// counter on frame_count; otherwise frame_count is a constant 0.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Reject configurations the 10-bit counters or the divider cannot represent.
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             p_tick_reg;
  logic [9:0]       h_reg;
  logic [9:0]       h_next;
  logic [9:0]       v_reg;
  logic [9:0]       v_next;
  logic             hsync_reg;
  logic             hsync_next;
  logic             vsync_reg;
  logic             vsync_next;
  logic             video_on_reg;
  logic             video_on_next;

  // Clock divider: wraps to 0 after CLK_DIV-1.
  always_comb begin
    div_next = div_reg + 1'b1;
    if (div_reg == DIV_LAST) begin
      div_next = '0;
    end
  end

  // Divider and pixel-enable registers; p_tick is a registered decode so it
  // is glitch-free and exactly one clk wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg    <= '0;
      p_tick_reg <= 1'b0;
    end else begin
      div_reg    <= div_next;
      p_tick_reg <= (div_reg == DIV_LAST);
    end
  end

  // Raster position: h advances per pixel, v advances on each line wrap.
  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (p_tick_reg) begin
      if (h_reg == H_LAST) begin
        h_next = '0;
        if (v_reg == V_LAST) begin
          v_next = '0;
        end else begin
          v_next = v_reg + 10'd1;
        end
      end else begin
        h_next = h_reg + 10'd1;
      end
    end
  end

  // Sync and blanking decode from the upcoming position, so the registered
  // versions change on the same edge as x/y and never lag them.
  always_comb begin
    hsync_next    = hsync_reg;
    vsync_next    = vsync_reg;
    video_on_next = video_on_reg;
    if (p_tick_reg) begin
      hsync_next    = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vsync_next    = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
      video_on_next = (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

  // Counter and timing-output registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_reg        <= '0;
      v_reg        <= '0;
      hsync_reg    <= 1'b1;
      vsync_reg    <= 1'b1;
      video_on_reg <= 1'b0;
    end else begin
      h_reg        <= h_next;
      v_reg        <= v_next;
      hsync_reg    <= hsync_next;
      vsync_reg    <= vsync_next;
      video_on_reg <= video_on_next;
    end
  end

  assign p_tick      = p_tick_reg;
  assign x           = h_reg;
  assign y           = v_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  // Last pixel of the frame is being presented and is about to retire.
  assign frame_start = p_tick_reg & (h_reg == H_LAST) & (v_reg == V_LAST);

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_reg;

  // Free-running frame counter for blink/animation timing; wraps 255 -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_reg <= 8'd0;
    end else if (frame_start) begin
      frame_count_reg <= frame_count_reg + 8'd1;
    end
  end

  assign frame_count = frame_count_reg;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized reset schedule against an arithmetic model.
// The model derives the expected raster state from the number of clocks
// elapsed since reset release; a monitor compares every clock and also
// measures sync pulse widths and frame_start spacing directly.
module tb_vga_timing_gen;

  localparam int TB_DIV = 4;
  localparam int TB_HD  = 20;
  localparam int TB_HF  = 4;
  localparam int TB_HS  = 6;
  localparam int TB_HB  = 5;
  localparam int TB_VD  = 10;
  localparam int TB_VF  = 2;
  localparam int TB_VS  = 2;
  localparam int TB_VB  = 3;
  localparam int H_TOT  = TB_HD + TB_HF + TB_HS + TB_HB;
  localparam int V_TOT  = TB_VD + TB_VF + TB_VS + TB_VB;
  localparam int FRAME_PIX  = H_TOT * V_TOT;
  localparam int FRAME_CLKS = FRAME_PIX * TB_DIV;

  typedef struct packed {
    int         n;
    logic       p;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
  logic [7:0] frame_count;

  exp_t exp_q[$];
  exp_t cur;
  int   n_model = 0;
  int   checks  = 0;
  int   errors  = 0;

  vga_timing_gen #(
    .CLK_DIV(TB_DIV), .H_DISPLAY(TB_HD), .H_FRONT(TB_HF), .H_SYNC(TB_HS),
    .H_BACK(TB_HB), .V_DISPLAY(TB_VD), .V_FRONT(TB_VF), .V_SYNC(TB_VS),
    .V_BACK(TB_VB)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
    .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Expected state after n clock edges since reset release (n=0: in reset).
  function automatic exp_t model(input int n);
    exp_t e;
    int   ticks;
    int   pix;
    int   px;
    int   py;
    ticks = (n == 0) ? 0 : (n - 1) / TB_DIV;
    pix   = ticks % FRAME_PIX;
    px    = pix % H_TOT;
    py    = pix / H_TOT;
    e.n   = n;
    e.p   = (n >= TB_DIV) && (n % TB_DIV == 0);
    e.x   = 10'(px);
    e.y   = 10'(py);
    e.von = (ticks > 0) && (px < TB_HD) && (py < TB_VD);
    e.hs  = !((px >= TB_HD + TB_HF) && (px < TB_HD + TB_HF + TB_HS));
    e.vs  = !((py >= TB_VD + TB_VF) && (py < TB_VD + TB_VF + TB_VS));
    e.fs  = e.p && (px == H_TOT - 1) && (py == V_TOT - 1);
`ifdef VGA_FRAME_COUNT_EN
    e.fc  = 8'((ticks / FRAME_PIX) % 256);
`else
    e.fc  = 8'd0;
`endif
    return e;
  endfunction

  // One clock: account for the edge just taken and queue its expectation.
  task automatic step();
    @(posedge clk);
    if (reset) n_model = 0;
    else       n_model = n_model + 1;
    cur = model(n_model);
    exp_q.push_back(cur);
    #1;
  endtask

  task automatic run_phase(input logic r, input int cycles);
    reset = r;
    repeat (cycles) step();
  endtask

  // Run until the model sits at (tx,ty), then reset for exactly one clock.
  task automatic reset_at(input int tx, input int ty);
    int guard;
    reset = 1'b0;
    guard = 0;
    while (!(cur.x == 10'(tx) && cur.y == 10'(ty)) && guard < 2 * FRAME_CLKS) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 2 * FRAME_CLKS) begin
      errors++;
      $display("FAIL reset_at: position (%0d,%0d) not reached, got (%0d,%0d)",
               tx, ty, cur.x, cur.y);
    end
    run_phase(1'b1, 1);
  endtask

  // Monitor: pop one expectation per clock and compare all outputs, plus
  // direct measurements of hsync/vsync low width and frame_start spacing.
  int  cyc = 0;
  int  hs_run = 0;
  int  vs_run = 0;
  int  last_fs = 0;
  bit  fs_have = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({p_tick, x, y, video_on, hsync, vsync, frame_start, frame_count} !==
            {e.p, e.x, e.y, e.von, e.hs, e.vs, e.fs, e.fc}) begin
          errors++;
          $display("FAIL outputs n=%0d: got p=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b fc=%0d, expected p=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b fc=%0d",
                   e.n, p_tick, x, y, video_on, hsync, vsync, frame_start, frame_count,
                   e.p, e.x, e.y, e.von, e.hs, e.vs, e.fs, e.fc);
        end
        if (e.n == 0) begin
          hs_run  = 0;
          vs_run  = 0;
          fs_have = 1'b0;
        end else begin
          if (hsync === 1'b0) hs_run++;
          else if (hs_run > 0) begin
            checks++;
            if (hs_run != TB_HS * TB_DIV) begin
              errors++;
              $display("FAIL hsync_width: got %0d clks, expected %0d", hs_run, TB_HS * TB_DIV);
            end
            hs_run = 0;
          end
          if (vsync === 1'b0) vs_run++;
          else if (vs_run > 0) begin
            checks++;
            if (vs_run != TB_VS * H_TOT * TB_DIV) begin
              errors++;
              $display("FAIL vsync_width: got %0d clks, expected %0d", vs_run, TB_VS * H_TOT * TB_DIV);
            end
            vs_run = 0;
          end
          if (frame_start === 1'b1) begin
            if (fs_have) begin
              checks++;
              if (cyc - last_fs != FRAME_CLKS) begin
                errors++;
                $display("FAIL frame_spacing: got %0d clks, expected %0d", cyc - last_fs, FRAME_CLKS);
              end
            end
            last_fs = cyc;
            fs_have = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    cur   = model(0);
    reset = 1'b1;
    run_phase(1'b1, 10);
    run_phase(1'b0, 3 * FRAME_CLKS);
    // Mid-frame reset, then a randomly placed one.
    reset_at(17, 8);
    run_phase(1'b0, 2 * FRAME_CLKS + 50);
    reset_at($urandom_range(1, H_TOT - 1), $urandom_range(1, V_TOT - 1));
    run_phase(1'b0, FRAME_CLKS + 7);
    for (int k = 0; k < 6; k++) begin
      run_phase(1'b1, $urandom_range(1, 3));
      run_phase(1'b0, $urandom_range(50, FRAME_CLKS));
    end
    run_phase(1'b0, 2 * FRAME_CLKS);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
